// File: rtl/stat_resp_misr.sv
// stat_resp_misr: folds a stream of 32-bit benchmark output vectors into a
// MISR signature over a programmed vector count, then compares it to a golden value.
module stat_resp_misr #(
  parameter int unsigned       WIDTH = 32,
  parameter int unsigned       CNT_W = 16,
  parameter logic [WIDTH-1:0]  POLY  = 32'h0040_0007,
  parameter logic [WIDTH-1:0]  SEED  = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0] golden,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_data,
  output logic             resp_ready,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   sig_q;
  logic [WIDTH-1:0]   sig_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   num_q;
  logic [WIDTH-1:0]   golden_q;
  logic               ready_q;
  logic               busy_q;
  logic               done_q;
  logic               pass_q;
  logic               xfer;

  assign xfer = resp_valid & ready_q;

  // Next MISR value and next count for an accepted vector
  always_comb begin
    sig_d = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp_data;
    cnt_d = cnt_q + CNT_W'(1);
  end

  // Control FSM with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sig_q    <= SEED;
      cnt_q    <= '0;
      num_q    <= '0;
      golden_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            num_q    <= num_vec;
            golden_q <= golden;
            sig_q    <= SEED;
            cnt_q    <= '0;
            if (num_vec == '0) begin
              // Empty run completes immediately on the seed value
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (golden == SEED);
            end else begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
              pass_q  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            sig_q <= sig_d;
            cnt_q <= cnt_d;
            // Final vector: compare against the value being written this edge
            if (cnt_d == num_q) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (sig_d == golden_q);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pass_q  <= 1'b0;
        end
      endcase
    end
  end

  assign resp_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign signature  = sig_q;
  assign vec_count  = cnt_q;

endmodule
